// File: rtl/spi_master_if.sv
// SPI master bus bundle: request/handshake signals from the register file
// plus the external SPI pins.
//   master modport : the spi_master block (drives data_out..cs_out_n)
//   slave modport  : the controller/pin side (drives start_in..serial_in)
//   start_in, data_in, cs_select_in, mode_in, clk_div_in, serial_in : requests, MISO
//   data_out, busy_out, done_out, clk_out, serial_out, cs_out_n     : results, SCLK/MOSI/CS
interface spi_master_if #(
    parameter int SIZE     = 40,
    parameter int CS_COUNT = 1,
    parameter int CLK_SIZE = 8
);
    localparam int CS_SEL = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;

    logic                start_in;
    logic [SIZE-1:0]     data_in;
    logic [CS_SEL-1:0]   cs_select_in;
    logic [1:0]          mode_in;
    logic [CLK_SIZE-1:0] clk_div_in;
    logic                serial_in;
    logic [SIZE-1:0]     data_out;
    logic                busy_out;
    logic                done_out;
    logic                clk_out;
    logic                serial_out;
    logic [CS_COUNT-1:0] cs_out_n;

    modport master (
        input  start_in, data_in, cs_select_in, mode_in, clk_div_in, serial_in,
        output data_out, busy_out, done_out, clk_out, serial_out, cs_out_n
    );

    modport slave (
        output start_in, data_in, cs_select_in, mode_in, clk_div_in, serial_in,
        input  data_out, busy_out, done_out, clk_out, serial_out, cs_out_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: one frame per start request, four CPOL/CPHA modes, decoded
// active-low chip selects and a runtime SCLK divider.
// Ports: clk_in (posedge), rst_n_in (async, active low), bus (spi_master_if.master).
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting;
// default is MSB-first in both directions.
module spi_master #(
    parameter int SIZE     = 40,
    parameter int CS_COUNT = 1,
    parameter int CLK_SIZE = 8
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    spi_master_if.master bus
);
    localparam int EW = $clog2(2 * SIZE);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * SIZE - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CLK_SIZE-1:0] div_q;
    logic [CLK_SIZE-1:0] cnt_q;
    logic [EW-1:0]       edge_q;
    logic                tail_q;
    logic                cpha_q;
    logic [SIZE-1:0]     tx_q;
    logic [SIZE-1:0]     rx_q;
    logic [SIZE-1:0]     data_q;
    logic                busy_q;
    logic                done_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [CS_COUNT-1:0] cs_n_q;
    logic [CS_COUNT-1:0] cs_dec_n;

    logic                tick;
    logic                accept;
    logic                lead_edge;
    logic                shift_en;
    logic                sample_en;
    logic                finish;

    logic                load_bit;
    logic [SIZE-1:0]     load_rest;
    logic                tx_bit;
    logic [SIZE-1:0]     tx_next;
    logic [SIZE-1:0]     rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign load_bit  = bus.data_in[0];
    assign load_rest = bus.data_in >> 1;
    assign tx_bit    = tx_q[0];
    assign tx_next   = tx_q >> 1;
    assign rx_next   = {bus.serial_in, rx_q[SIZE-1:1]};
`else
    assign load_bit  = bus.data_in[SIZE-1];
    assign load_rest = bus.data_in << 1;
    assign tx_bit    = tx_q[SIZE-1];
    assign tx_next   = tx_q << 1;
    assign rx_next   = {rx_q[SIZE-2:0], bus.serial_in};
`endif

    // Out-of-range index leaves every select deasserted.
    always_comb begin
        cs_dec_n = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (int'(bus.cs_select_in) == i) cs_dec_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        finish    = 1'b0;
        tick      = (cnt_q == div_q);
        // Even edge count: SCLK is about to leave CPOL (leading edge).
        lead_edge = (edge_q[0] == 1'b0);
        unique case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    accept  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    // CPHA=1 shifts on leading edges, CPHA=0 on trailing.
                    shift_en  = (lead_edge == cpha_q);
                    sample_en = (lead_edge != cpha_q);
                    if (edge_q == LAST_EDGE) state_d = TRAIL;
                end
            end
            TRAIL: begin
                // tail_q marks the end of the CS hold half-period.
                if (tail_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q  <= '0;
            cnt_q  <= '0;
            edge_q <= '0;
            tail_q <= 1'b0;
            cpha_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= '1;
        end else begin
            done_q <= finish;
            if (state_q == IDLE || tick) cnt_q <= '0;
            else                         cnt_q <= cnt_q + 1'b1;
            tail_q <= (state_q == TRAIL) && !finish && (tail_q || tick);
            if (state_q == IDLE) sclk_q <= bus.mode_in[1];
            if (accept) begin
                div_q  <= bus.clk_div_in;
                cpha_q <= bus.mode_in[0];
                edge_q <= '0;
                rx_q   <= '0;
                busy_q <= 1'b1;
                cs_n_q <= cs_dec_n;
                // CPHA=0 needs the first bit on MOSI before the first edge.
                if (bus.mode_in[0]) begin
                    tx_q <= bus.data_in;
                end else begin
                    tx_q   <= load_rest;
                    mosi_q <= load_bit;
                end
            end
            if (state_q == XFER && tick) begin
                sclk_q <= ~sclk_q;
                edge_q <= edge_q + 1'b1;
            end
            if (shift_en) begin
                tx_q   <= tx_next;
                mosi_q <= tx_bit;
            end
            if (sample_en) rx_q <= rx_next;
            if (finish) begin
                busy_q <= 1'b0;
                cs_n_q <= '1;
                data_q <= rx_q;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.busy_out   = busy_q;
    assign bus.done_out   = done_q;
    assign bus.clk_out    = sclk_q;
    assign bus.serial_out = mosi_q;
    assign bus.cs_out_n   = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: bus-level slave model, random words,
// directed mode/divider/CS/reset scenarios.
module tb_spi_master;
    localparam int SIZE     = 40;
    localparam int CS_COUNT = 5;
    localparam int CLK_SIZE = 8;
    localparam logic [CS_COUNT-1:0] CS_IDLE = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mosi_hi = 0;

    spi_master_if #(.SIZE(SIZE), .CS_COUNT(CS_COUNT), .CLK_SIZE(CLK_SIZE)) b ();

    spi_master #(.SIZE(SIZE), .CS_COUNT(CS_COUNT), .CLK_SIZE(CLK_SIZE)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[SIZE-1:0];
    endfunction

    // Word position of the k-th bit on the wire.
    function automatic int pos(int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return k;
`else
        return SIZE - 1 - k;
`endif
    endfunction

    task automatic run_frame(input logic [SIZE-1:0] d, input logic [2:0] sel,
                             input logic [1:0] mode, input logic [7:0] div,
                             input logic [SIZE-1:0] mw, input bit loop,
                             input int poke_at, input bit hold);
        int cyc = 0, busy_n = 0, rise_n = 0, fall_n = 0;
        int gap_bad = 0, last_c = 0, edges = 0, ns = 0, mi = 0;
        bit fin = 0, cs_bad = 0, cs_seen = 0;
        logic prev;
        logic [SIZE-1:0] mosi_w = '0;
        logic [SIZE-1:0] exp_rx;
        logic [CS_COUNT-1:0] cs_exp = '1;
        if (int'(sel) < CS_COUNT) cs_exp[sel] = 1'b0;
        exp_rx = loop ? d : mw;
        mosi_hi = 0;
        @(negedge clk);
        b.data_in = d;
        b.cs_select_in = sel;
        b.mode_in = mode;
        b.clk_div_in = div;
        b.start_in = 1'b0;
        @(negedge clk);
        chk("idle_sclk", 64'(b.clk_out), 64'(mode[1]));
        b.start_in = 1'b1;
        if (!mode[0] && !loop) begin
            b.serial_in = mw[pos(0)];
            mi = 1;
        end
        @(negedge clk);
        if (!hold) begin
            b.start_in = 1'b0;
            b.data_in = rnd();
            b.cs_select_in = 3'($urandom());
            b.mode_in = 2'($urandom());
            b.clk_div_in = 8'($urandom());
        end
        prev = mode[1];
        while (!fin && cyc < 3000) begin
            if (b.busy_out) busy_n++;
            if (b.done_out) fin = 1;
            if (b.serial_out && b.busy_out) mosi_hi++;
            if (b.cs_out_n == cs_exp && cs_exp != CS_IDLE) cs_seen = 1;
            else if (b.cs_out_n != CS_IDLE) cs_bad = 1;
            if (b.clk_out != prev) begin
                edges++;
                if (b.clk_out) rise_n++;
                else fall_n++;
                if (edges > 1 && cyc - last_c != int'(div) + 1) gap_bad++;
                last_c = cyc;
                // Leading edge leaves CPOL; CPHA=0 samples there, CPHA=1 on the other.
                if ((b.clk_out != mode[1]) ^ mode[0]) begin
                    if (ns < SIZE) mosi_w[pos(ns)] = b.serial_out;
                    ns++;
                end else if (!loop) begin
                    b.serial_in = (mi < SIZE) ? mw[pos(mi)] : 1'b0;
                    mi++;
                end
            end
            prev = b.clk_out;
            if (loop) b.serial_in = b.serial_out;
            b.start_in = hold || (cyc == poke_at);
            if (cyc == poke_at) b.data_in = rnd();
            cyc++;
            if (!fin) @(negedge clk);
        end
        chk("done_seen", 64'(fin), 64'(1));
        chk("busy_drop", 64'(b.busy_out), 64'(0));
        chk("busy_len", 64'(busy_n), 64'(2 * (SIZE + 1) * (int'(div) + 1) + 1));
        chk("sclk_rise", 64'(rise_n), 64'(SIZE));
        chk("sclk_fall", 64'(fall_n), 64'(SIZE));
        chk("sclk_gap", 64'(gap_bad), 64'(0));
        chk("mosi_word", 64'(mosi_w), 64'(d));
        chk("cs_other", 64'(cs_bad), 64'(0));
        if (cs_exp != CS_IDLE) chk("cs_low", 64'(cs_seen), 64'(1));
        chk("cs_end", 64'(b.cs_out_n), 64'(CS_IDLE));
        chk("rx_word", 64'(b.data_out), 64'(exp_rx));
        chk("sclk_end", 64'(b.clk_out), 64'(mode[1]));
        @(negedge clk);
        chk("done_pulse", 64'(b.done_out), 64'(0));
        if (hold) begin
            chk("rearm", 64'(b.busy_out), 64'(1));
            b.start_in = 1'b0;
            cyc = 0;
            fin = 0;
            while (!fin && cyc < 3000) begin
                b.serial_in = b.serial_out;
                if (b.done_out) fin = 1;
                else begin
                    cyc++;
                    @(negedge clk);
                end
            end
            chk("b2b_done", 64'(fin), 64'(1));
            chk("b2b_data", 64'(b.data_out), 64'(d));
        end else begin
            chk("rx_hold", 64'(b.data_out), 64'(exp_rx));
        end
    endtask

    initial begin
        b.start_in = 1'b1;
        b.data_in = rnd();
        b.cs_select_in = 3'($urandom());
        b.mode_in = 2'($urandom());
        b.clk_div_in = 8'($urandom());
        b.serial_in = 1'($urandom());
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(b.cs_out_n), 64'(CS_IDLE));
        chk("rst_sclk", 64'(b.clk_out), 64'(0));
        chk("rst_busy", 64'(b.busy_out), 64'(0));
        chk("rst_done", 64'(b.done_out), 64'(0));
        chk("rst_data", 64'(b.data_out), 64'(0));
        chk("rst_mosi", 64'(b.serial_out), 64'(0));
        b.start_in = 1'b0;
        b.mode_in = 2'd0;
        rst_n = 1'b1;

        run_frame(40'hA5_0F_3C_96_C3, 3'd2, 2'd0, 8'd0, '0, 1, -1, 0);
        for (int m = 1; m < 4; m++) begin
            run_frame(rnd(), 3'($urandom_range(0, 4)), 2'(m), 8'd3, rnd(), 0, -1, 0);
        end
        run_frame(rnd(), 3'd5, 2'd0, 8'd1, rnd(), 0, -1, 0);
        run_frame(rnd(), 3'd1, 2'd3, 8'd0, rnd(), 0, 15, 0);

        @(negedge clk);
        b.data_in = rnd();
        b.cs_select_in = 3'd1;
        b.mode_in = 2'd0;
        b.clk_div_in = 8'd0;
        b.start_in = 1'b1;
        @(negedge clk);
        b.start_in = 1'b0;
        repeat (10) @(negedge clk);
        b.start_in = 1'b1;
        b.data_in = rnd();
        @(negedge clk);
        b.start_in = 1'b0;
        chk("mid_busy", 64'(b.busy_out), 64'(1));
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_cs", 64'(b.cs_out_n), 64'(CS_IDLE));
        chk("mrst_sclk", 64'(b.clk_out), 64'(0));
        chk("mrst_busy", 64'(b.busy_out), 64'(0));
        chk("mrst_done", 64'(b.done_out), 64'(0));
        chk("mrst_data", 64'(b.data_out), 64'(0));
        chk("mrst_mosi", 64'(b.serial_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(rnd(), 3'd4, 2'd1, 8'd2, rnd(), 0, -1, 0);

        run_frame(rnd(), 3'd0, 2'd0, 8'd0, '0, 1, -1, 1);

        run_frame(40'h1, 3'd2, 2'd0, 8'd0, rnd(), 0, -1, 0);
        chk("mosi_hi", 64'(mosi_hi), 64'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
